// File: rtl/axis_arb_pkg.sv
// Shared definitions for the two-port AXI-Stream packet arbiter: state
// encoding, default stream widths and packet counter width.
package axis_arb_pkg;

   localparam int ARB_DATA_WIDTH  = 512;
   localparam int ARB_TUSER_WIDTH = 128;
   localparam int ARB_CNT_WIDTH   = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_pkt_counter.sv
// Free-running per-port packet counter, wraps at all-ones.
// Only built when ARB_PKT_CNT_EN is defined.
`ifdef ARB_PKT_CNT_EN
module arb_pkt_counter
   import axis_arb_pkg::*;
(
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic                     inc,
   output logic [ARB_CNT_WIDTH-1:0] count
);

   logic [ARB_CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + ARB_CNT_WIDTH'(1);
      end
   end

   assign count = cnt_q;

endmodule
`endif

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream master between
// two slave ports. Define ARB_PKT_CNT_EN to add per-port packet counters.
module axis_pkt_arbiter
   import axis_arb_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = ARB_DATA_WIDTH,
   parameter int C_S_AXIS_TUSER_WIDTH = ARB_TUSER_WIDTH
)(
   input  logic                              clk,
   input  logic                              aresetn,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
   input  logic                              s0_axis_tvalid,
   output logic                              s0_axis_tready,
   input  logic                              s0_axis_tlast,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
   input  logic                              s1_axis_tvalid,
   output logic                              s1_axis_tready,
   input  logic                              s1_axis_tlast,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast
`ifdef ARB_PKT_CNT_EN
   ,
   output logic [ARB_CNT_WIDTH-1:0]          pkt_cnt_0,
   output logic [ARB_CNT_WIDTH-1:0]          pkt_cnt_1
`endif
);

   arb_state_t state_q, state_d;
   logic       last_grant_q;
   logic       last_beat_0, last_beat_1;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (last_beat_0) begin
            last_grant_q <= 1'b0;
         end else if (last_beat_1) begin
            last_grant_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      m_axis_tdata   = '0;
      m_axis_tkeep   = '0;
      m_axis_tuser   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      last_beat_0    = 1'b0;
      last_beat_1    = 1'b0;

      case (state_q)
         IDLE: begin
            // On a tie the port that did not finish the previous packet wins.
            if (s0_axis_tvalid && s1_axis_tvalid) begin
               state_d = last_grant_q ? GRANT0 : GRANT1;
            end else if (s0_axis_tvalid) begin
               state_d = GRANT0;
            end else if (s1_axis_tvalid) begin
               state_d = GRANT1;
            end
         end

         GRANT0: begin
            m_axis_tdata   = s0_axis_tdata;
            m_axis_tkeep   = s0_axis_tkeep;
            m_axis_tuser   = s0_axis_tuser;
            m_axis_tvalid  = s0_axis_tvalid;
            m_axis_tlast   = s0_axis_tlast;
            s0_axis_tready = m_axis_tready;
            if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
               last_beat_0 = 1'b1;
               state_d     = s1_axis_tvalid ? GRANT1 : IDLE;
            end
         end

         GRANT1: begin
            m_axis_tdata   = s1_axis_tdata;
            m_axis_tkeep   = s1_axis_tkeep;
            m_axis_tuser   = s1_axis_tuser;
            m_axis_tvalid  = s1_axis_tvalid;
            m_axis_tlast   = s1_axis_tlast;
            s1_axis_tready = m_axis_tready;
            if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
               last_beat_1 = 1'b1;
               state_d     = s0_axis_tvalid ? GRANT0 : IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

`ifdef ARB_PKT_CNT_EN
   arb_pkt_counter u_cnt_0 (
      .clk     (clk),
      .aresetn (aresetn),
      .inc     (last_beat_0),
      .count   (pkt_cnt_0)
   );

   arb_pkt_counter u_cnt_1 (
      .clk     (clk),
      .aresetn (aresetn),
      .inc     (last_beat_1),
      .count   (pkt_cnt_1)
   );
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomized bench for axis_pkt_arbiter against a packet-level arbitration model.
// Counter checks are included when ARB_PKT_CNT_EN is defined.
module tb_axis_pkt_arbiter;

   localparam int DW = 64;
   localparam int UW = 16;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          aresetn;
   logic [DW-1:0] s0_axis_tdata,  s1_axis_tdata,  m_axis_tdata;
   logic [KW-1:0] s0_axis_tkeep,  s1_axis_tkeep,  m_axis_tkeep;
   logic [UW-1:0] s0_axis_tuser,  s1_axis_tuser,  m_axis_tuser;
   logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
   logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
   logic          s0_axis_tlast,  s1_axis_tlast,  m_axis_tlast;
`ifdef ARB_PKT_CNT_EN
   logic [31:0]   pkt_cnt_0, pkt_cnt_1;
`endif

   axis_pkt_arbiter #(
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_TUSER_WIDTH (UW)
   ) dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tkeep  (s0_axis_tkeep),
      .s0_axis_tuser  (s0_axis_tuser),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tready (s0_axis_tready),
      .s0_axis_tlast  (s0_axis_tlast),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tkeep  (s1_axis_tkeep),
      .s1_axis_tuser  (s1_axis_tuser),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tready (s1_axis_tready),
      .s1_axis_tlast  (s1_axis_tlast),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tkeep   (m_axis_tkeep),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast)
`ifdef ARB_PKT_CNT_EN
      ,
      .pkt_cnt_0      (pkt_cnt_0),
      .pkt_cnt_1      (pkt_cnt_1)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Model: per-port packet queues, current owner (-1 none) and last winner.
   beat_t       q0[$], q1[$];
   int          own, lastg;
   logic [31:0] cnt0, cnt1;
   int          done[$];
   bit          rnd_valid, mute0, mute1, pend0, pend1, tog;
   int          rdy_mode;
   int          cyc, x_first, x_last, x_count;
   int unsigned sent0, sent1, dacc0, dacc1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t rand_beat();
      beat_t       b;
      logic [31:0] r0, r1, r2;
      r0     = $urandom;
      r1     = $urandom;
      r2     = $urandom;
      b.data = {r0, r1};
      b.keep = r2[KW-1:0];
      b.user = r2[KW+UW-1:KW];
      b.last = r2[31];
      return b;
   endfunction

   task automatic add_pkt(input int port, input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b      = rand_beat();
         b.last = (i == n - 1);
         if (port == 0) begin
            q0.push_back(b);
            sent0++;
         end else begin
            q1.push_back(b);
            sent1++;
         end
      end
   endtask

   task automatic start_test();
      done.delete();
      x_first = -1;
      x_last  = -1;
      x_count = 0;
      sent0   = 0;
      sent1   = 0;
      dacc0   = 0;
      dacc1   = 0;
   endtask

   // One clock: drive at negedge, compare against model, advance model.
   task automatic step();
      logic  v0, v1, mr, xv, exp_mv, exp_r0, exp_r1;
      beat_t f0, f1, em;
      int    nxt;
      @(negedge clk);
      v0 = (q0.size() != 0) && !mute0 && (pend0 || !rnd_valid || ($urandom_range(0, 3) != 0));
      v1 = (q1.size() != 0) && !mute1 && (pend1 || !rnd_valid || ($urandom_range(0, 3) != 0));
      f0 = v0 ? q0[0] : rand_beat();
      f1 = v1 ? q1[0] : rand_beat();
      case (rdy_mode)
         0:       mr = 1'b1;
         1:       begin mr = tog; tog = ~tog; end
         default: mr = ($urandom_range(0, 1) == 1);
      endcase
      s0_axis_tvalid = v0;
      s0_axis_tdata  = f0.data;
      s0_axis_tkeep  = f0.keep;
      s0_axis_tuser  = f0.user;
      s0_axis_tlast  = f0.last;
      s1_axis_tvalid = v1;
      s1_axis_tdata  = f1.data;
      s1_axis_tkeep  = f1.keep;
      s1_axis_tuser  = f1.user;
      s1_axis_tlast  = f1.last;
      m_axis_tready  = mr;
      #1;
      em     = '0;
      exp_mv = 1'b0;
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (own == 0) begin
         exp_mv = v0; exp_r0 = mr; em = f0;
      end else if (own == 1) begin
         exp_mv = v1; exp_r1 = mr; em = f1;
      end
      chk("m_tvalid",  64'(m_axis_tvalid),  64'(exp_mv));
      chk("s0_tready", 64'(s0_axis_tready), 64'(exp_r0));
      chk("s1_tready", 64'(s1_axis_tready), 64'(exp_r1));
      chk("m_tdata",   64'(m_axis_tdata),   64'(em.data));
      chk("m_tkeep",   64'(m_axis_tkeep),   64'(em.keep));
      chk("m_tuser",   64'(m_axis_tuser),   64'(em.user));
      chk("m_tlast",   64'(m_axis_tlast),   64'(em.last));
`ifdef ARB_PKT_CNT_EN
      chk("pkt_cnt_0", 64'(pkt_cnt_0), 64'(cnt0));
      chk("pkt_cnt_1", 64'(pkt_cnt_1), 64'(cnt1));
`endif
      if (v0 && s0_axis_tready) dacc0++;
      if (v1 && s1_axis_tready) dacc1++;
      nxt   = own;
      pend0 = v0;
      pend1 = v1;
      if (own < 0) begin
         if (v0 && v1)  nxt = (lastg == 1) ? 0 : 1;
         else if (v0)   nxt = 0;
         else if (v1)   nxt = 1;
      end else begin
         xv = (own == 0) ? v0 : v1;
         if (xv && mr) begin
            if (x_first < 0) x_first = cyc;
            x_last = cyc;
            x_count++;
            if (own == 0) begin
               pend0 = 1'b0;
               void'(q0.pop_front());
            end else begin
               pend1 = 1'b0;
               void'(q1.pop_front());
            end
            if (em.last) begin
               lastg = own;
               if (own == 0) cnt0++;
               else          cnt1++;
               done.push_back(own);
               if (own == 0) nxt = v1 ? 1 : -1;
               else          nxt = v0 ? 0 : -1;
            end
         end
      end
      own = nxt;
      cyc++;
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || own >= 0) && n < max_cyc) begin
         step();
         n++;
      end
      chk("drain_q0", 64'(q0.size()), 64'd0);
      chk("drain_q1", 64'(q1.size()), 64'd0);
      chk("beats_s0", 64'(dacc0), 64'(sent0));
      chk("beats_s1", 64'(dacc1), 64'(sent1));
   endtask

   task automatic chk_order(input int exp_q[$]);
      chk("order_len", 64'(done.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < done.size(); i++) begin
         chk("order", 64'(done[i]), 64'(exp_q[i]));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      aresetn        = 1'b0;
      s0_axis_tvalid = 1'b0;
      s1_axis_tvalid = 1'b0;
      m_axis_tready  = 1'b0;
      q0.delete();
      q1.delete();
      own   = -1;
      lastg = 1;
      cnt0  = '0;
      cnt1  = '0;
      pend0 = 1'b0;
      pend1 = 1'b0;
      tog   = 1'b1;
      #1;
      chk("rst_tvalid",  64'(m_axis_tvalid),  64'd0);
      chk("rst_tready0", 64'(s0_axis_tready), 64'd0);
      chk("rst_tready1", 64'(s1_axis_tready), 64'd0);
      chk("rst_tdata",   64'(m_axis_tdata),   64'd0);
      chk("rst_tlast",   64'(m_axis_tlast),   64'd0);
      chk("rst_state",   64'(dut.state_q),    64'd0);
`ifdef ARB_PKT_CNT_EN
      chk("rst_cnt0", 64'(pkt_cnt_0), 64'd0);
      chk("rst_cnt1", 64'(pkt_cnt_1), 64'd0);
`endif
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ord[$];
      logic [31:0] c0_save;
      aresetn        = 1'b0;
      s0_axis_tvalid = 1'b0;
      s1_axis_tvalid = 1'b0;
      s0_axis_tdata  = '0; s0_axis_tkeep = '0; s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
      s1_axis_tdata  = '0; s1_axis_tkeep = '0; s1_axis_tuser = '0; s1_axis_tlast = 1'b0;
      m_axis_tready  = 1'b0;
      rnd_valid = 1'b0; mute0 = 1'b0; mute1 = 1'b0; rdy_mode = 0; cyc = 0;
      own = -1; lastg = 1; cnt0 = '0; cnt1 = '0;
      do_reset();

      // s0 alone, 3-beat packet
      start_test();
      add_pkt(0, 3);
      drain(20);
      ord = '{0};
      chk_order(ord);
      chk("s0_beats_fwd", 64'(x_count), 64'd3);

      // both ports busy from reset: strict alternation, no bubble
      do_reset();
      start_test();
      add_pkt(0, 2); add_pkt(1, 2); add_pkt(0, 2); add_pkt(1, 2);
      drain(40);
      ord = '{0, 1, 0, 1};
      chk_order(ord);
      chk("no_bubble", 64'(x_last - x_first + 1), 64'd8);

      // downstream ready toggling 1010 during an s1 packet
      start_test();
      rdy_mode = 1;
      tog      = 1'b1;
      add_pkt(1, 4);
      drain(40);
      rdy_mode = 0;
      chk("tog_beats", 64'(x_count), 64'd4);

      // s0 pauses mid-packet while s1 waits: grant held until s0 tlast
      start_test();
      add_pkt(0, 4); add_pkt(1, 2);
      step(); step(); step();
      mute0 = 1'b1;
      step(); step();
      mute0 = 1'b0;
      drain(40);
      ord = '{0, 1};
      chk_order(ord);

      // single-beat packets back to back
      start_test();
      for (int i = 0; i < 3; i++) begin
         add_pkt(0, 1);
         add_pkt(1, 1);
      end
      drain(40);
      ord = '{0, 1, 0, 1, 0, 1};
      chk_order(ord);
      chk("single_span", 64'(x_last - x_first + 1), 64'd6);

      // reset asserted in the middle of an s0 packet
      start_test();
      add_pkt(0, 4); add_pkt(1, 2);
      step(); step(); step();
      #2;
      aresetn = 1'b0;
      #1;
      chk("async_rst_tvalid", 64'(m_axis_tvalid),  64'd0);
      chk("async_rst_tready", 64'(s0_axis_tready), 64'd0);
      do_reset();
      start_test();
      add_pkt(1, 2); add_pkt(0, 2);
      drain(40);
      ord = '{0, 1};
      chk_order(ord);

`ifdef ARB_PKT_CNT_EN
      // s1 counter wraps from all-ones, s0 counter untouched
      start_test();
      add_pkt(0, 1);
      drain(20);
      step();
      c0_save = cnt0;
      force dut.u_cnt_1.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_cnt_1.cnt_q;
      cnt1 = 32'hFFFF_FFFF;
      add_pkt(1, 2);
      drain(20);
      step();
      chk("wrap_cnt1", 64'(pkt_cnt_1), 64'd0);
      chk("keep_cnt0", 64'(pkt_cnt_0), 64'(c0_save));
`endif

      // randomized traffic with random valid gaps and backpressure
      start_test();
      rnd_valid = 1'b1;
      rdy_mode  = 2;
      for (int i = 0; i < 600; i++) begin
         if (q0.size() < 6 && $urandom_range(0, 3) == 0) add_pkt(0, int'($urandom_range(1, 4)));
         if (q1.size() < 6 && $urandom_range(0, 3) == 0) add_pkt(1, int'($urandom_range(1, 4)));
         step();
      end
      drain(3000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 512, tdata width of all three streams.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, tuser (metadata) width of all three streams.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports s0_axis_tdata / s1_axis_tdata  input  C_S_AXIS_DATA_WIDTH  requester payload.
REQ-006 SHALL have ports s0_axis_tkeep / s1_axis_tkeep  input  C_S_AXIS_DATA_WIDTH/8  byte enables.
REQ-007 SHALL have ports s0_axis_tuser / s1_axis_tuser  input  C_S_AXIS_TUSER_WIDTH  metadata.
REQ-008 SHALL have ports s0_axis_tvalid / s1_axis_tvalid  input  1  beat valid.
REQ-009 SHALL have ports s0_axis_tready / s1_axis_tready  output  1  beat accepted.
REQ-010 SHALL have ports s0_axis_tlast / s1_axis_tlast  input  1  last beat of packet.
REQ-011 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tuser  output  same widths  payload to shared extract pipeline.
REQ-012 SHALL have ports m_axis_tvalid, m_axis_tlast  output  1 each; m_axis_tready  input  1.
REQ-013 SHALL have ports pkt_cnt_0 / pkt_cnt_1  output  32  packets forwarded per port (only with ARB_PKT_CNT_EN).

Function
REQ-014 SHALL share the m_axis datapath between s0 and s1 with packet-granular round-robin; a granted packet is never interleaved.
REQ-015 SHALL implement states IDLE, GRANT0, GRANT1, plus 1-bit register last_grant.
REQ-016 In IDLE: s0 valid only -> GRANT0; s1 valid only -> GRANT1; both valid -> port != last_grant; neither -> stay IDLE.
REQ-017 In IDLE: m_axis_tvalid=0, both s*_axis_tready=0, m_axis tdata/tkeep/tuser/tlast driven 0.
REQ-018 In GRANTx: m_axis_* = sx_axis_* combinationally (0-cycle latency); sx_axis_tready = m_axis_tready; other port tready=0.
REQ-019 Last beat = sx_tvalid & m_axis_tready & sx_tlast in GRANTx; on that edge last_grant<=x.
REQ-020 On last beat: other port tvalid high -> GRANT_other directly (no bubble); else -> IDLE.
REQ-021 Single-beat packets (tvalid & tlast on first beat) SHALL complete in one cycle per REQ-019/020.
REQ-022 Backpressure: while m_axis_tready=0 state SHALL hold and no beat SHALL be consumed.
REQ-023 A sender deasserting tvalid mid-packet SHALL keep the grant until its tlast beat.

Reset
REQ-024 aresetn=0 SHALL force state=IDLE, last_grant=1 (port 0 wins first tie), counters=0, all outputs as REQ-017.
REQ-025 Reset mid-packet SHALL abandon the packet; downstream truncation is accepted behaviour.

Configuration
REQ-026 Macro ARB_PKT_CNT_EN defined: pkt_cnt_0/1 SHALL exist, increment by 1 on each last beat of that port, wrap 0xFFFFFFFF->0.
REQ-027 ARB_PKT_CNT_EN undefined: pkt_cnt ports and counter logic SHALL be absent; arbitration identical.

Structure
REQ-028 Shared package axis_arb_pkg SHALL hold state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and default width constants.
REQ-029 Counters SHALL be one sub-module arb_pkt_counter, instantiated per port under ARB_PKT_CNT_EN.

Verification
REQ-030 Bench: s0 sends 3-beat packet, s1 idle, m_axis_tready=1 -> m_axis copies 3 beats, tlast on beat 3, s1_axis_tready always 0.
REQ-031 Bench: both valid from reset with 2-beat packets -> order s0,s1,s0,s1, no idle cycle between packets.
REQ-032 Bench: m_axis_tready toggles 1010 during s1 packet -> s1 beat held stable, accepted only when tready=1, no duplicates/drops.
REQ-033 Bench: s0 drops tvalid 2 cycles mid-packet while s1 valid -> grant stays s0 until its tlast, then s1.
REQ-034 Bench: aresetn pulsed low mid-packet -> next cycle m_axis_tvalid=0, state IDLE, counters 0; next tie goes to s0.
REQ-035 Bench (ARB_PKT_CNT_EN): preload 0xFFFFFFFF via force, send one s1 packet -> pkt_cnt_1=0, pkt_cnt_0 unchanged.
